// File: rtl/if_id_latch.sv
// IF/ID pipeline register with stall, flush, miss-bubble and halt lock.
// Also keeps saturating stall/flush event counters for debug.
module if_id_latch #(
    parameter int unsigned  WORD_W   = 32,
    parameter logic [31:0]  NOP_WORD = 32'h0,
    parameter logic [5:0]   HALT_OP  = 6'h3F,
    parameter int unsigned  CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              dmem_pend,
    input  logic              dhit,
    input  logic              flush,
    output logic [WORD_W-1:0] instr_IF_ID,
    output logic [5:0]        opcode_IF_ID,
    output logic [5:0]        func_IF_ID,
    output logic [4:0]        rs_IF_ID,
    output logic [4:0]        rt_IF_ID,
    output logic [4:0]        rd_IF_ID,
    output logic [4:0]        shamt_IF_ID,
    output logic [15:0]       imm16_IF_ID,
    output logic [25:0]       addr26_IF_ID,
    output logic [WORD_W-1:0] npc_IF_ID,
    output logic              valid_IF_ID,
    output logic              halt_lock,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [WORD_W-1:0] NOP = WORD_W'(NOP_WORD);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic              valid_q, valid_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              freeze;

    assign freeze = stall | (dmem_pend & ~dhit);

    always_comb begin
        instr_d     = instr_q;
        npc_d       = npc_q;
        valid_d     = valid_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            // A HALT on a squashed path must not keep fetch locked
            instr_d = NOP;
            valid_d = 1'b0;
            halt_d  = 1'b0;
            if (flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (freeze) begin
            if (stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (halt_q) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (ihit) begin
            instr_d = imemload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
            if (imemload[31:26] == HALT_OP)
                halt_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q     <= NOP;
            npc_q       <= '0;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign instr_IF_ID  = instr_q;
    assign opcode_IF_ID = instr_q[31:26];
    assign func_IF_ID   = instr_q[5:0];
    assign rs_IF_ID     = instr_q[25:21];
    assign rt_IF_ID     = instr_q[20:16];
    assign rd_IF_ID     = instr_q[15:11];
    assign shamt_IF_ID  = instr_q[10:6];
    assign imm16_IF_ID  = instr_q[15:0];
    assign addr26_IF_ID = instr_q[25:0];
    assign npc_IF_ID    = npc_q;
    assign valid_IF_ID  = valid_q;
    assign halt_lock    = halt_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_latch.sv
// Directed testbench for if_id_latch.
// Each scenario task checks its own expected values inline.
module tb_if_id_latch;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic [31:0] pc_plus4 = '0;
    logic        stall = 1'b0;
    logic        dmem_pend = 1'b0;
    logic        dhit = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_IF_ID;
    logic [5:0]  opcode_IF_ID;
    logic [5:0]  func_IF_ID;
    logic [4:0]  rs_IF_ID;
    logic [4:0]  rt_IF_ID;
    logic [4:0]  rd_IF_ID;
    logic [4:0]  shamt_IF_ID;
    logic [15:0] imm16_IF_ID;
    logic [25:0] addr26_IF_ID;
    logic [31:0] npc_IF_ID;
    logic        valid_IF_ID;
    logic        halt_lock;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    if_id_latch dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .pc_plus4(pc_plus4), .stall(stall), .dmem_pend(dmem_pend),
        .dhit(dhit), .flush(flush), .instr_IF_ID(instr_IF_ID),
        .opcode_IF_ID(opcode_IF_ID), .func_IF_ID(func_IF_ID),
        .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .rd_IF_ID(rd_IF_ID),
        .shamt_IF_ID(shamt_IF_ID), .imm16_IF_ID(imm16_IF_ID),
        .addr26_IF_ID(addr26_IF_ID), .npc_IF_ID(npc_IF_ID),
        .valid_IF_ID(valid_IF_ID), .halt_lock(halt_lock),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 0; stall = 0; dmem_pend = 0; dhit = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] pc);
        ihit = 1; imemload = w; pc_plus4 = pc;
        tick();
        ihit = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (instr_IF_ID !== 32'h0 || valid_IF_ID !== 1'b0 ||
            halt_lock !== 1'b0 || npc_IF_ID !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: instr=%h valid=%b halt=%b npc=%h want 0/0/0/0",
                     instr_IF_ID, valid_IF_ID, halt_lock, npc_IF_ID);
        end
        total++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_cnt: stall=%h flush=%h want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load();
        load(32'h2008_0005, 32'h4);
        total++;
        if (opcode_IF_ID !== 6'h08 || rt_IF_ID !== 5'd8 || rs_IF_ID !== 5'd0 ||
            imm16_IF_ID !== 16'h5 || npc_IF_ID !== 32'h4 || valid_IF_ID !== 1'b1) begin
            bad++;
            $display("FAIL load_fields: op=%h rs=%0d rt=%0d imm=%h npc=%h v=%b want 08/0/8/0005/4/1",
                     opcode_IF_ID, rs_IF_ID, rt_IF_ID, imm16_IF_ID, npc_IF_ID, valid_IF_ID);
        end
        load(32'h0109_5020, 32'h8);
        total++;
        if (rs_IF_ID !== 5'd8 || rt_IF_ID !== 5'd9 || rd_IF_ID !== 5'd10 ||
            shamt_IF_ID !== 5'd0 || func_IF_ID !== 6'h20 ||
            addr26_IF_ID !== 26'h109_5020) begin
            bad++;
            $display("FAIL rtype_fields: rs=%0d rt=%0d rd=%0d sh=%0d fn=%h a26=%h want 8/9/10/0/20/1095020",
                     rs_IF_ID, rt_IF_ID, rd_IF_ID, shamt_IF_ID, func_IF_ID, addr26_IF_ID);
        end
        tick();
        total++;
        if (instr_IF_ID !== 32'h0 || valid_IF_ID !== 1'b0 || npc_IF_ID !== 32'h8) begin
            bad++;
            $display("FAIL miss_bubble: instr=%h v=%b npc=%h want 0/0/8",
                     instr_IF_ID, valid_IF_ID, npc_IF_ID);
        end
    endtask

    task automatic test_stall();
        do_reset();
        load(32'h0109_5020, 32'h10);
        stall = 1; ihit = 1; imemload = 32'h2222_3333; pc_plus4 = 32'h14;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (instr_IF_ID !== 32'h0109_5020 || npc_IF_ID !== 32'h10 ||
            valid_IF_ID !== 1'b1 || stall_cnt !== 16'd3) begin
            bad++;
            $display("FAIL stall_hold: instr=%h npc=%h v=%b cnt=%0d want 01095020/10/1/3",
                     instr_IF_ID, npc_IF_ID, valid_IF_ID, stall_cnt);
        end
        stall = 0;
        tick();
        ihit = 0;
        total++;
        if (instr_IF_ID !== 32'h2222_3333 || npc_IF_ID !== 32'h14 || stall_cnt !== 16'd3) begin
            bad++;
            $display("FAIL stall_release: instr=%h npc=%h cnt=%0d want 22223333/14/3",
                     instr_IF_ID, npc_IF_ID, stall_cnt);
        end
    endtask

    task automatic test_dmem();
        do_reset();
        load(32'h1111_0000, 32'h20);
        dmem_pend = 1; dhit = 0; ihit = 1; imemload = 32'h8C42_0004; pc_plus4 = 32'h24;
        tick();
        tick();
        total++;
        if (instr_IF_ID !== 32'h1111_0000 || stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL dmem_hold: instr=%h cnt=%0d want 11110000/2", instr_IF_ID, stall_cnt);
        end
        dhit = 1;
        tick();
        idle();
        total++;
        if (instr_IF_ID !== 32'h8C42_0004 || npc_IF_ID !== 32'h24 || stall_cnt !== 16'd2) begin
            bad++;
            $display("FAIL dmem_dhit: instr=%h npc=%h cnt=%0d want 8c420004/24/2",
                     instr_IF_ID, npc_IF_ID, stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        load(32'h1234_5678, 32'h30);
        flush = 1; stall = 1; ihit = 1; imemload = 32'hAAAA_5555; pc_plus4 = 32'h34;
        tick();
        idle();
        total++;
        if (instr_IF_ID !== 32'h0 || valid_IF_ID !== 1'b0 || npc_IF_ID !== 32'h30 ||
            flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL flush_prio: instr=%h v=%b npc=%h fc=%0d sc=%0d want 0/0/30/1/0",
                     instr_IF_ID, valid_IF_ID, npc_IF_ID, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        load(32'hFFFF_FFFF, 32'h40);
        total++;
        if (halt_lock !== 1'b1 || instr_IF_ID !== 32'hFFFF_FFFF || valid_IF_ID !== 1'b1) begin
            bad++;
            $display("FAIL halt_set: halt=%b instr=%h v=%b want 1/ffffffff/1",
                     halt_lock, instr_IF_ID, valid_IF_ID);
        end
        load(32'h2008_0001, 32'h44);
        total++;
        if (instr_IF_ID !== 32'h0 || valid_IF_ID !== 1'b0 ||
            halt_lock !== 1'b1 || npc_IF_ID !== 32'h40) begin
            bad++;
            $display("FAIL halt_block: instr=%h v=%b halt=%b npc=%h want 0/0/1/40",
                     instr_IF_ID, valid_IF_ID, halt_lock, npc_IF_ID);
        end
        flush = 1;
        tick();
        flush = 0;
        total++;
        if (halt_lock !== 1'b0 || flush_cnt !== 16'd1) begin
            bad++;
            $display("FAIL halt_flush: halt=%b fc=%0d want 0/1", halt_lock, flush_cnt);
        end
        load(32'h2008_0001, 32'h48);
        total++;
        if (instr_IF_ID !== 32'h2008_0001 || valid_IF_ID !== 1'b1 || npc_IF_ID !== 32'h48) begin
            bad++;
            $display("FAIL halt_resume: instr=%h v=%b npc=%h want 20080001/1/48",
                     instr_IF_ID, valid_IF_ID, npc_IF_ID);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load(32'h5555_AAAA, 32'h50);
        stall = 1; RST = 1; ihit = 1; imemload = 32'h7777_7777;
        tick();
        RST = 0;
        total++;
        if (instr_IF_ID !== 32'h0 || valid_IF_ID !== 1'b0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_stall: instr=%h v=%b sc=%0d want 0/0/0",
                     instr_IF_ID, valid_IF_ID, stall_cnt);
        end
        idle();
        tick();
        total++;
        if (valid_IF_ID !== 1'b0 || instr_IF_ID !== 32'h0) begin
            bad++;
            $display("FAIL rst_bubble: instr=%h v=%b want 0/0", instr_IF_ID, valid_IF_ID);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        stall = 1;
        for (int i = 0; i < 65534; i++) tick();
        total++;
        if (stall_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_pre: stall_cnt=%h want fffe", stall_cnt);
        end
        for (int i = 0; i < 3; i++) tick();
        stall = 0;
        total++;
        if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL sat_hold: stall_cnt=%h flush_cnt=%h want ffff/0", stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_dmem();
        test_flush();
        test_halt();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
